// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of inst_encoder.
// master = producer/consumer side, slave = encoder side.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_code;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;

    modport master (
        output in_valid, in_code, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst
    );

    modport slave (
        input  in_valid, in_code, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I field-bundle to instruction-word encoder with output FIFO.
// Define INST_ENCODER_STRICT_EN to drop bundles whose immediate does not fit its format.
module inst_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    inst_encoder_if.slave               bus,
    output logic                        err_pulse,
    output logic [1:0]                  err_code,
    output logic [ERR_CNT_W-1:0]        err_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]          LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]        PTR_ONE = AW'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    function automatic logic code_legal(input logic [11:0] code);
        logic [2:0] f3;
        logic       ok;
        f3 = code[9:7];
        case (code[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            OP_JALR:   ok = (f3 == 3'b000);
            OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OP_STORE:  ok = (f3 <= 3'b010);
            OP_OPIMM:  ok = !code[11];
            OP_OP:     ok = !code[10] && (!code[11] || (f3 == 3'b000) || (f3 == 3'b101));
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(input logic [11:0] code, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] w;
        op = code[6:0];
        f3 = code[9:7];
        case (op)
            OP_LUI, OP_AUIPC:  w = {imm[31:12], rd, op};
            OP_JAL:            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            OP_JALR, OP_LOAD:  w = {imm[11:0], rs1, f3, rd, op};
            OP_BRANCH:         w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_STORE:          w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_OPIMM: begin
                // funct3 001/101 are the shifts: shamt in [24:20], arith flag at bit 30
                if (f3[1:0] == 2'b01) begin
                    w = {1'b0, code[10], 5'b00000, imm[4:0], rs1, f3, rd, op};
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                end
            end
            OP_OP:             w = {1'b0, code[11], 5'b00000, rs2, rs1, f3, rd, op};
            default:           w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef INST_ENCODER_STRICT_EN
    function automatic logic imm_fits(input logic [11:0] code, input logic [31:0] imm);
        logic ok;
        case (code[6:0])
            OP_LUI, OP_AUIPC:           ok = (imm[11:0] == 12'd0);
            OP_JAL:                     ok = !imm[0] && (imm[31:20] == {12{imm[20]}});
            OP_BRANCH:                  ok = !imm[0] && (imm[31:12] == {20{imm[12]}});
            OP_JALR, OP_LOAD, OP_STORE: ok = (imm[31:11] == {21{imm[11]}});
            OP_OPIMM: begin
                if (code[8:7] == 2'b01) begin
                    ok = (imm[31:5] == 27'd0);
                end else begin
                    ok = (imm[31:11] == {21{imm[11]}});
                end
            end
            default:                    ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic [31:0]   enc_s;
    logic [1:0]    enc_err_s;
    logic          full_s, pop_s, retire_s, push_s, accept_s, drop_s;
    logic          s_valid_r;
    logic [31:0]   s_inst_r;
    logic [1:0]    s_err_r;
    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   level_r;

    // Encode the incoming bundle and classify it; illegal code outranks a bad immediate.
    always_comb begin
        enc_s = encode(bus.in_code, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        if (!code_legal(bus.in_code)) begin
            enc_err_s = 2'b01;
`ifdef INST_ENCODER_STRICT_EN
        end else if (!imm_fits(bus.in_code, bus.in_imm)) begin
            enc_err_s = 2'b10;
`endif
        end else begin
            enc_err_s = 2'b00;
        end
    end

    // Stage retire and handshake; an erroneous stage entry never waits for FIFO space.
    always_comb begin
        full_s   = (level_r == DEPTH_L);
        pop_s    = bus.out_ready && (level_r != '0);
        retire_s = s_valid_r && ((s_err_r != 2'b00) || !full_s || pop_s);
        push_s   = retire_s && (s_err_r == 2'b00);
        drop_s   = retire_s && (s_err_r != 2'b00) && !flush;
        accept_s = bus.in_valid && (!s_valid_r || retire_s) && !flush;
    end

    assign bus.in_ready  = !s_valid_r || retire_s;
    assign bus.out_valid = (level_r != '0);
    assign bus.out_inst  = mem_r[rd_ptr_r];
    assign fifo_level    = level_r;

    // Stage register S holds the already-encoded word and its error class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_r <= 1'b0;
            s_inst_r  <= 32'd0;
            s_err_r   <= 2'b00;
        end else if (flush) begin
            s_valid_r <= 1'b0;
        end else if (accept_s) begin
            s_valid_r <= 1'b1;
            s_inst_r  <= enc_s;
            s_err_r   <= enc_err_s;
        end else if (retire_s) begin
            s_valid_r <= 1'b0;
        end
    end

    // Output FIFO; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= s_inst_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LVL_ONE;
            end
        end
    end

    // Dropped-bundle reporting; err_cnt survives flush and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_code  <= 2'b00;
            err_cnt   <= '0;
        end else begin
            err_pulse <= drop_s;
            if (drop_s) begin
                err_code <= s_err_r;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end
endmodule
